// File: rtl/dmem_axi_master.sv
// dmem_axi_master
// ---------------
// Data-memory AXI4 master bridge for the CPU core's MEM-stage data port.
// Each load or store from the core becomes one single-beat AXI4 read or
// write transaction. The pipeline is held with stall_o until the response
// returns. In the DONE cycle stall_o drops for one cycle so the held request
// retires, and load data is already visible on rdata_o.
//
// Ports
//   ACLK, ARESETn      clock, asynchronous active-low reset
//   addr_i             core data address
//   ren_i / wen_i      core load / store request (store wins if both set)
//   wstrb_i, wdata_i   store byte strobe and data
//   rdata_o            registered load data, held until the next load
//   stall_o            combinational pipeline stall
//   err_o              one-cycle pulse in DONE when the response was bad
//   AR*/R*             AXI4 read address / read data channels
//   AW*/W*/B*          AXI4 write address / write data / write response

module dmem_axi_master #(
   parameter int AXI_ID_BITS   = 4,
   parameter int AXI_ADDR_BITS = 32,
   parameter int AXI_DATA_BITS = 32,
   parameter int MASTER_ID     = 1
) (
   input  logic                       ACLK,
   input  logic                       ARESETn,
   input  logic [AXI_ADDR_BITS-1:0]   addr_i,
   input  logic                       ren_i,
   input  logic                       wen_i,
   input  logic [AXI_DATA_BITS/8-1:0] wstrb_i,
   input  logic [AXI_DATA_BITS-1:0]   wdata_i,
   output logic [AXI_DATA_BITS-1:0]   rdata_o,
   output logic                       stall_o,
   output logic                       err_o,
   output logic [AXI_ID_BITS-1:0]     ARID,
   output logic [AXI_ADDR_BITS-1:0]   ARADDR,
   output logic [7:0]                 ARLEN,
   output logic [2:0]                 ARSIZE,
   output logic [1:0]                 ARBURST,
   output logic                       ARVALID,
   input  logic                       ARREADY,
   input  logic [AXI_ID_BITS-1:0]     RID,
   input  logic [AXI_DATA_BITS-1:0]   RDATA,
   input  logic [1:0]                 RRESP,
   input  logic                       RLAST,
   input  logic                       RVALID,
   output logic                       RREADY,
   output logic [AXI_ID_BITS-1:0]     AWID,
   output logic [AXI_ADDR_BITS-1:0]   AWADDR,
   output logic [7:0]                 AWLEN,
   output logic [2:0]                 AWSIZE,
   output logic [1:0]                 AWBURST,
   output logic                       AWVALID,
   input  logic                       AWREADY,
   output logic [AXI_DATA_BITS-1:0]   WDATA,
   output logic [AXI_DATA_BITS/8-1:0] WSTRB,
   output logic                       WLAST,
   output logic                       WVALID,
   input  logic                       WREADY,
   input  logic [AXI_ID_BITS-1:0]     BID,
   input  logic [1:0]                 BRESP,
   input  logic                       BVALID,
   output logic                       BREADY
);

   localparam int                     STRB_BITS = AXI_DATA_BITS / 8;
   localparam logic [AXI_ID_BITS-1:0] MID       = AXI_ID_BITS'(MASTER_ID);
   localparam logic [2:0]             AXSIZE    = 3'($clog2(STRB_BITS));

   typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, DONE} StateT;

   StateT                     state;
   StateT                     nextState;
   logic [AXI_ADDR_BITS-1:0]  addrReg;
   logic [AXI_DATA_BITS-1:0]  wdataReg;
   logic [STRB_BITS-1:0]      wstrbReg;
   logic                      awDone;
   logic                      wDone;
   logic                      errFlag;
   logic                      unusedRlast;

   // Every transaction is a single beat, so the last-beat marker on the
   // read channel carries no information for us.
   assign unusedRlast = RLAST;

   // Fixed AXI attributes: single-beat INCR bursts of full bus width, tagged
   // with our master ID. Payload always comes from the captured request so it
   // stays stable while VALID waits for READY, whatever the core does.
   assign ARID    = MID;
   assign ARADDR  = addrReg;
   assign ARLEN   = 8'd0;
   assign ARSIZE  = AXSIZE;
   assign ARBURST = 2'b01;
   assign AWID    = MID;
   assign AWADDR  = addrReg;
   assign AWLEN   = 8'd0;
   assign AWSIZE  = AXSIZE;
   assign AWBURST = 2'b01;
   assign WDATA   = wdataReg;
   assign WSTRB   = wstrbReg;
   assign WLAST   = 1'b1;

   // The stall is combinational so it rises in the same cycle a request
   // first shows up in IDLE. It is forced low while reset is held because the
   // whole interconnect is being reset along with us.
   assign stall_o = ARESETn &&
                    (((state == IDLE) && (ren_i || wen_i)) ||
                     (state inside {AR, R, AW_W, B}));

   assign err_o = (state == DONE) && errFlag;

   // State register. Reset is asynchronous so that every VALID/READY, which
   // is decoded from the state, drops the moment ARESETn falls.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state and handshake decode. In AW_W the two write channels are
   // independent: each VALID drops after its own handshake, and we move on
   // once both are done, whether the handshakes landed in one cycle or two.
   always_comb begin
      nextState = state;
      ARVALID   = 1'b0;
      RREADY    = 1'b0;
      AWVALID   = 1'b0;
      WVALID    = 1'b0;
      BREADY    = 1'b0;
      case (state)
         IDLE: begin
            if (wen_i) begin
               nextState = AW_W;
            end else if (ren_i) begin
               nextState = AR;
            end
         end
         AR: begin
            ARVALID = 1'b1;
            if (ARREADY) nextState = R;
         end
         R: begin
            RREADY = 1'b1;
            if (RVALID) nextState = DONE;
         end
         AW_W: begin
            AWVALID = !awDone;
            WVALID  = !wDone;
            if ((awDone || AWREADY) && (wDone || WREADY)) nextState = B;
         end
         B: begin
            BREADY = 1'b1;
            if (BVALID) nextState = DONE;
         end
         DONE: begin
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Request capture, write-channel completion flags, load data and the
   // response error flag. The error flag is overwritten by every response,
   // so a bad response never leaks into the next access. Stores leave
   // rdata_o alone.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         addrReg  <= '0;
         wdataReg <= '0;
         wstrbReg <= '0;
         awDone   <= 1'b0;
         wDone    <= 1'b0;
         errFlag  <= 1'b0;
         rdata_o  <= '0;
      end else begin
         case (state)
            IDLE: begin
               awDone <= 1'b0;
               wDone  <= 1'b0;
               if (wen_i || ren_i) addrReg <= addr_i;
               if (wen_i) begin
                  wdataReg <= wdata_i;
                  wstrbReg <= wstrb_i;
               end
            end
            R: begin
               if (RVALID) begin
                  rdata_o <= RDATA;
                  errFlag <= (RRESP != 2'b00) || (RID != MID);
               end
            end
            AW_W: begin
               awDone <= awDone || AWREADY;
               wDone  <= wDone || WREADY;
            end
            B: begin
               if (BVALID) errFlag <= (BRESP != 2'b00) || (BID != MID);
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_axi_master.sv
// tb_dmem_axi_master
// ------------------
// Drives the bridge with core requests and a scripted AXI slave whose READY
// and VALID delays are chosen per transaction. From those delays the bench
// works out, cycle by cycle, what stall_o, every VALID/READY, the payload,
// err_o and rdata_o must be. One compare process checks them at every
// falling edge. A few directed transactions also pin hand-computed totals
// (stall length, handshake counts, captured data).

module tb_dmem_axi_master;

   logic        ACLK = 1'b0;
   logic        ARESETn;
   logic [31:0] addr_i;
   logic        ren_i;
   logic        wen_i;
   logic [3:0]  wstrb_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;
   logic        stall_o;
   logic        err_o;
   logic [3:0]  ARID;
   logic [31:0] ARADDR;
   logic [7:0]  ARLEN;
   logic [2:0]  ARSIZE;
   logic [1:0]  ARBURST;
   logic        ARVALID;
   logic        ARREADY;
   logic [3:0]  RID;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RLAST;
   logic        RVALID;
   logic        RREADY;
   logic [3:0]  AWID;
   logic [31:0] AWADDR;
   logic [7:0]  AWLEN;
   logic [2:0]  AWSIZE;
   logic [1:0]  AWBURST;
   logic        AWVALID;
   logic        AWREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WLAST;
   logic        WVALID;
   logic        WREADY;
   logic [3:0]  BID;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY;

   // Expected outputs for the current cycle, written by the stimulus side.
   logic        expOn = 1'b0;
   logic        eFirst, eLast;
   logic        eStall, eArv, eRr, eAwv, eWv, eBr, eErr;
   logic [31:0] eAddr, eWdata, eRdata;
   logic [3:0]  eWstrb;
   logic [31:0] lastRdata;

   // Hand-computed totals for directed transactions (-1 = not checked).
   logic        litOn = 1'b0;
   int          litStall, litArHs, litAwHs, litWHs, litErr, litArv, litAwv, litWv;
   longint      litRdata, litAddr, litWstrb;

   // Per-transaction measurements gathered by the compare process.
   int          stallCnt, arHs, awHs, wHs, errCnt, arvCnt, awvCnt, wvCnt;
   logic [31:0] seenAraddr;
   logic [3:0]  seenWstrb;

   int          checks = 0;
   int          errors = 0;

   always #5 ACLK = ~ACLK;

   dmem_axi_master #(
      .AXI_ID_BITS(4), .AXI_ADDR_BITS(32), .AXI_DATA_BITS(32), .MASTER_ID(1)
   ) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .addr_i(addr_i), .ren_i(ren_i), .wen_i(wen_i), .wstrb_i(wstrb_i), .wdata_i(wdata_i),
      .rdata_o(rdata_o), .stall_o(stall_o), .err_o(err_o),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
   );

   // One comparison: count it, and report it if the values differ.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, req, $time);
      end
   endtask

   // Background stimulus: random core payload with no request, and random
   // slave signals. Each transaction overrides what its schedule pins down;
   // everything left random must be ignored by the bridge.
   task automatic applyStimulus();
      addr_i  = $urandom;
      wdata_i = $urandom;
      wstrb_i = 4'($urandom);
      ren_i   = 1'b0;
      wen_i   = 1'b0;
      ARREADY = 1'($urandom);
      AWREADY = 1'($urandom);
      WREADY  = 1'($urandom);
      RVALID  = 1'($urandom);
      RDATA   = $urandom;
      RID     = 4'($urandom);
      RRESP   = 2'($urandom);
      RLAST   = 1'($urandom);
      BVALID  = 1'($urandom);
      BID     = 4'($urandom);
      BRESP   = 2'($urandom);
   endtask

   task automatic setIdleExp();
      eFirst = 1'b0; eLast = 1'b0;
      eStall = 1'b0; eArv = 1'b0; eRr = 1'b0;
      eAwv = 1'b0; eWv = 1'b0; eBr = 1'b0; eErr = 1'b0;
      eRdata = lastRdata;
   endtask

   task automatic clearLit();
      litOn = 1'b0;
      litStall = -1; litArHs = -1; litAwHs = -1; litWHs = -1;
      litErr = -1; litArv = -1; litAwv = -1; litWv = -1;
      litRdata = -1; litAddr = -1; litWstrb = -1;
   endtask

   task automatic runIdle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge ACLK); #2;
         applyStimulus();
         setIdleExp();
      end
   endtask

   // Load: ARREADY comes a cycles after ARVALID rises, RVALID r cycles after
   // entering the data phase. Cycle 0 is the request, 1..a+1 the address
   // phase, a+2..a+2+r the data phase, a+3+r the retire cycle. A
   // non-negative abortAt pulls reset mid data phase with RVALID pending.
   task automatic runRead(input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] resp, input logic [3:0] id,
                          input int a, input int r, input int abortAt);
      int doneK = a + 3 + r;
      for (int k = 0; k <= doneK; k++) begin
         @(posedge ACLK); #2;
         applyStimulus();
         ren_i = 1'b1;
         if (k == 0) addr_i = addr;
         if (k >= 1 && k <= a + 1) ARREADY = (k == a + 1);
         if (k >= a + 2 && k <= a + 2 + r) begin
            RVALID = (k == a + 2 + r) || (k == abortAt);
            if (RVALID) begin
               RDATA = data; RRESP = resp; RID = id;
            end
         end
         setIdleExp();
         eFirst = (k == 0);
         eLast  = (k == doneK);
         eStall = (k <= a + 2 + r);
         eArv   = (k >= 1 && k <= a + 1);
         eRr    = (k >= a + 2 && k <= a + 2 + r);
         eAddr  = addr;
         if (k == doneK) begin
            lastRdata = data;
            eRdata    = data;
            eErr      = (resp != 2'b00) || (id != 4'd1);
         end
         if (k == abortAt) begin
            #1 ARESETn = 1'b0;
            lastRdata = '0;
            setIdleExp();
            @(posedge ACLK); #2;
            applyStimulus();
            setIdleExp();
            ARESETn = 1'b1;
            break;
         end
      end
      @(negedge ACLK); #1;
   endtask

   // Store: AWREADY comes aw cycles and WREADY w cycles after the VALIDs
   // rise together, BVALID b cycles into the response phase. The response
   // phase starts one cycle after the later of the two handshakes.
   task automatic runWrite(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] bresp,
                           input logic [3:0] bid, input int aw, input int w,
                           input int b, input logic alsoRead);
      int m     = (aw > w) ? aw : w;
      int doneK = m + 3 + b;
      for (int k = 0; k <= doneK; k++) begin
         @(posedge ACLK); #2;
         applyStimulus();
         wen_i = 1'b1;
         ren_i = alsoRead;
         if (k == 0) begin
            addr_i = addr; wdata_i = data; wstrb_i = strb;
         end
         if (k >= 1 && k <= aw + 1) AWREADY = (k == aw + 1);
         if (k >= 1 && k <= w + 1) WREADY = (k == w + 1);
         if (k >= m + 2 && k <= m + 2 + b) begin
            BVALID = (k == m + 2 + b);
            if (BVALID) begin
               BRESP = bresp; BID = bid;
            end
         end
         setIdleExp();
         eFirst = (k == 0);
         eLast  = (k == doneK);
         eStall = (k <= m + 2 + b);
         eAwv   = (k >= 1 && k <= aw + 1);
         eWv    = (k >= 1 && k <= w + 1);
         eBr    = (k >= m + 2 && k <= m + 2 + b);
         eAddr  = addr; eWdata = data; eWstrb = strb;
         if (k == doneK) eErr = (bresp != 2'b00) || (bid != 4'd1);
      end
      @(negedge ACLK); #1;
   endtask

   function automatic logic [1:0] pickResp();
      return ($urandom % 5 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
   endfunction

   function automatic logic [3:0] pickId();
      return ($urandom % 8 == 0) ? 4'($urandom_range(2, 15)) : 4'd1;
   endfunction

   function automatic int pickDelay();
      return ($urandom % 6 == 0) ? int'($urandom_range(4, 7)) : int'($urandom % 4);
   endfunction

   // Compare process: every falling edge while expectations are live, check
   // all outputs, gather per-transaction totals, and at the retire cycle of a
   // directed transaction check those totals against hand-computed values.
   always @(negedge ACLK) begin
      if (expOn) begin
         if (eFirst) begin
            stallCnt = 0; arHs = 0; awHs = 0; wHs = 0;
            errCnt = 0; arvCnt = 0; awvCnt = 0; wvCnt = 0;
            seenAraddr = '0; seenWstrb = '0;
         end
         checkOutput("stall_o", 64'(stall_o), 64'(eStall));
         checkOutput("ARVALID", 64'(ARVALID), 64'(eArv));
         checkOutput("RREADY",  64'(RREADY),  64'(eRr));
         checkOutput("AWVALID", 64'(AWVALID), 64'(eAwv));
         checkOutput("WVALID",  64'(WVALID),  64'(eWv));
         checkOutput("BREADY",  64'(BREADY),  64'(eBr));
         checkOutput("err_o",   64'(err_o),   64'(eErr));
         checkOutput("rdata_o", 64'(rdata_o), 64'(eRdata));
         if (eArv) begin
            checkOutput("ARADDR",  64'(ARADDR),  64'(eAddr));
            checkOutput("ARID",    64'(ARID),    64'd1);
            checkOutput("ARLEN",   64'(ARLEN),   64'd0);
            checkOutput("ARSIZE",  64'(ARSIZE),  64'd2);
            checkOutput("ARBURST", 64'(ARBURST), 64'd1);
         end
         if (eAwv) begin
            checkOutput("AWADDR",  64'(AWADDR),  64'(eAddr));
            checkOutput("AWID",    64'(AWID),    64'd1);
            checkOutput("AWLEN",   64'(AWLEN),   64'd0);
            checkOutput("AWSIZE",  64'(AWSIZE),  64'd2);
            checkOutput("AWBURST", 64'(AWBURST), 64'd1);
         end
         if (eWv) begin
            checkOutput("WDATA", 64'(WDATA), 64'(eWdata));
            checkOutput("WSTRB", 64'(WSTRB), 64'(eWstrb));
            checkOutput("WLAST", 64'(WLAST), 64'd1);
         end
         stallCnt += int'(stall_o);
         errCnt   += int'(err_o);
         arvCnt   += int'(ARVALID);
         awvCnt   += int'(AWVALID);
         wvCnt    += int'(WVALID);
         if (ARVALID && ARREADY) begin
            arHs++; seenAraddr = ARADDR;
         end
         if (AWVALID && AWREADY) awHs++;
         if (WVALID && WREADY) begin
            wHs++; seenWstrb = WSTRB;
         end
         if (eLast && litOn) begin
            if (litStall >= 0) checkOutput("lit stall cycles", 64'(stallCnt), 64'(litStall));
            if (litArHs >= 0)  checkOutput("lit AR handshakes", 64'(arHs), 64'(litArHs));
            if (litAwHs >= 0)  checkOutput("lit AW handshakes", 64'(awHs), 64'(litAwHs));
            if (litWHs >= 0)   checkOutput("lit W handshakes", 64'(wHs), 64'(litWHs));
            if (litErr >= 0)   checkOutput("lit err_o cycles", 64'(errCnt), 64'(litErr));
            if (litArv >= 0)   checkOutput("lit ARVALID cycles", 64'(arvCnt), 64'(litArv));
            if (litAwv >= 0)   checkOutput("lit AWVALID cycles", 64'(awvCnt), 64'(litAwv));
            if (litWv >= 0)    checkOutput("lit WVALID cycles", 64'(wvCnt), 64'(litWv));
            if (litRdata >= 0) checkOutput("lit rdata_o", 64'(rdata_o), 64'(litRdata));
            if (litAddr >= 0)  checkOutput("lit ARADDR", 64'(seenAraddr), 64'(litAddr));
            if (litWstrb >= 0) checkOutput("lit WSTRB", 64'(seenWstrb), 64'(litWstrb));
         end
      end
   end

   initial begin
      int kind, a, r, aw, w, b;
      clearLit();
      lastRdata = '0;
      applyStimulus();
      ren_i   = 1'b1;
      wen_i   = 1'b1;
      ARESETn = 1'b0;
      setIdleExp();
      expOn   = 1'b1;
      repeat (2) @(posedge ACLK);
      #2;
      applyStimulus();
      setIdleExp();
      ARESETn = 1'b1;
      runIdle(2);

      // Zero-wait load of 0xDEADBEEF from 0x1000.
      clearLit(); litOn = 1'b1;
      litStall = 3; litArHs = 1; litArv = 1; litErr = 0;
      litRdata = 64'hDEADBEEF; litAddr = 64'h1000;
      runRead(32'h0000_1000, 32'hDEADBEEF, 2'b00, 4'd1, 0, 0, -1);
      clearLit();

      // Store with WREADY two cycles after AWREADY.
      litOn = 1'b1;
      litStall = 5; litAwHs = 1; litWHs = 1; litAwv = 1; litWv = 3;
      litArv = 0; litWstrb = 64'h3; litRdata = 64'hDEADBEEF;
      runWrite(32'h0000_2004, 32'h1234_5678, 4'b0011, 2'b00, 4'd1, 0, 2, 0, 1'b0);
      clearLit();

      // ARREADY held off four cycles while addr_i wanders.
      litOn = 1'b1;
      litStall = 7; litArHs = 1; litArv = 5; litAddr = 64'h3000;
      runRead(32'h0000_3000, 32'hA5A5_0001, 2'b00, 4'd1, 4, 0, -1);
      clearLit();

      // SLVERR load, then a clean load.
      litOn = 1'b1;
      litErr = 1; litStall = 5; litRdata = 64'hCAFEF00D;
      runRead(32'h0000_3100, 32'hCAFE_F00D, 2'b10, 4'd1, 1, 1, -1);
      clearLit();
      litOn = 1'b1;
      litErr = 0; litRdata = 64'h13572468;
      runRead(32'h0000_3104, 32'h1357_2468, 2'b00, 4'd1, 0, 0, -1);
      clearLit();

      // Load and store requested together: only the store goes out.
      litOn = 1'b1;
      litArv = 0; litArHs = 0; litAwHs = 1; litWHs = 1; litRdata = 64'h13572468;
      runWrite(32'h0000_4000, 32'h0F0F_0F0F, 4'b1111, 2'b00, 4'd1, 1, 0, 1, 1'b1);
      clearLit();

      // Reset during the data phase with RVALID pending, then a fresh load.
      runRead(32'h0000_4800, 32'h1111_1111, 2'b00, 4'd1, 0, 2, 3);
      runIdle(1);
      litOn = 1'b1;
      litStall = 3; litArHs = 1; litRdata = 64'h0BADC0DE; litAddr = 64'h5000;
      runRead(32'h0000_5000, 32'h0BAD_C0DE, 2'b00, 4'd1, 0, 0, -1);
      clearLit();

      // Randomized traffic against the schedule model.
      for (int i = 0; i < 200; i++) begin
         runIdle(int'($urandom % 3));
         kind = int'($urandom % 3);
         a  = pickDelay(); r = pickDelay();
         aw = pickDelay(); w = pickDelay(); b = pickDelay();
         if (kind == 0) begin
            runRead($urandom, $urandom, pickResp(), pickId(), a, r, -1);
         end else begin
            runWrite($urandom, $urandom, 4'($urandom), pickResp(), pickId(),
                     aw, w, b, kind == 2);
         end
      end

      runIdle(2);
      @(negedge ACLK); #1;
      expOn = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
